// File: rtl/unsdiv_seq_if.sv
// Handshake and operand bus of the iterative wide-word divider.
interface unsdiv_seq_if;
  logic         start;
  logic [0:127] reg_A;
  logic [0:127] reg_B;
  logic [0:1]   ctrl_ww;
  logic         busy;
  logic         done;
  logic [0:127] result;

  modport slave (
    input  start, reg_A, reg_B, ctrl_ww,
    output busy, done, result
  );

  modport master (
    output start, reg_A, reg_B, ctrl_ww,
    input  busy, done, result
  );
endinterface

// File: rtl/unsdiv_seq.sv
// Iterative unsigned wide-word divider: per 2w-bit lane, divides the 2w-bit
// dividend in reg_A by the low w-bit subfield of reg_B using restoring
// division, one quotient bit per lane per cycle, all lanes in parallel.
// Lanes are handled internally in little-endian order (lane 0 = LSBs);
// the packing back into result uses the same order, so it is transparent.
module unsdiv_seq (
  input logic         clk,
  input logic         reset,
  unsdiv_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;

  state_t        state_q, state_d;
  logic [6:0]    cnt_q, cnt_d;
  logic [1:0]    ww_q, ww_d;
  logic [63:0]   rem_q [8];   // partial remainder per lane
  logic [63:0]   rem_d [8];
  logic [63:0]   low_q [8];   // dividend low bits (MSB first) / quotient (LSBs)
  logic [63:0]   low_d [8];
  logic [63:0]   dvs_q [8];   // divisor per lane, zero-extended
  logic [63:0]   dvs_d [8];
  logic [7:0]    exc_q, exc_d; // lane saturates: divide by zero or overflow
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [127:0]  result_q, result_d;

  logic [127:0]  a_s, b_s;
  logic [63:0]   ld_hi_s [8];
  logic [63:0]   ld_lo_s [8];
  logic [63:0]   ld_dv_s [8];
  logic [7:0]    ld_exc_s;
  logic [63:0]   rem_nx_s [8];
  logic [63:0]   low_nx_s [8];
  logic [127:0]  res_s;

  assign a_s = bus.reg_A;
  assign b_s = bus.reg_B;

  // Split the input operands into lanes for the selected width.
  always_comb begin
    for (int j = 0; j < 8; j++) begin
      ld_hi_s[j] = 64'd0;
      ld_lo_s[j] = 64'd0;
      ld_dv_s[j] = 64'd0;
    end
    case (bus.ctrl_ww)
      2'b00: begin
        for (int j = 0; j < 8; j++) begin
          ld_hi_s[j] = {56'd0, a_s[j*16+8 +: 8]};
          ld_lo_s[j] = {a_s[j*16 +: 8], 56'd0};
          ld_dv_s[j] = {56'd0, b_s[j*16 +: 8]};
        end
      end
      2'b01: begin
        for (int j = 0; j < 4; j++) begin
          ld_hi_s[j] = {48'd0, a_s[j*32+16 +: 16]};
          ld_lo_s[j] = {a_s[j*32 +: 16], 48'd0};
          ld_dv_s[j] = {48'd0, b_s[j*32 +: 16]};
        end
      end
      2'b10: begin
        for (int j = 0; j < 2; j++) begin
          ld_hi_s[j] = {32'd0, a_s[j*64+32 +: 32]};
          ld_lo_s[j] = {a_s[j*64 +: 32], 32'd0};
          ld_dv_s[j] = {32'd0, b_s[j*64 +: 32]};
        end
      end
      default: begin
        ld_hi_s[0] = a_s[127:64];
        ld_lo_s[0] = a_s[63:0];
        ld_dv_s[0] = b_s[63:0];
      end
    endcase
    // A high half >= divisor means the quotient cannot fit in w bits.
    for (int j = 0; j < 8; j++) begin
      ld_exc_s[j] = (ld_dv_s[j] == 64'd0) || (ld_hi_s[j] >= ld_dv_s[j]);
    end
  end

  // One restoring shift-subtract step per lane; the trial value is one bit
  // wider than the remainder so the shifted-out bit is never lost.
  always_comb begin
    for (int j = 0; j < 8; j++) begin
      logic [64:0] trial;
      trial = {rem_q[j], low_q[j][63]};
      if (trial >= {1'b0, dvs_q[j]}) begin
        rem_nx_s[j] = 64'(trial - {1'b0, dvs_q[j]});
        low_nx_s[j] = {low_q[j][62:0], 1'b1};
      end else begin
        rem_nx_s[j] = trial[63:0];
        low_nx_s[j] = {low_q[j][62:0], 1'b0};
      end
    end
  end

  // Pack final remainder (even/high half) and quotient (odd/low half) per lane.
  always_comb begin
    res_s = 128'd0;
    case (ww_q)
      2'b00: begin
        for (int j = 0; j < 8; j++) begin
          res_s[j*16 +: 8]   = exc_q[j] ? 8'hFF : low_nx_s[j][7:0];
          res_s[j*16+8 +: 8] = exc_q[j] ? 8'h00 : rem_nx_s[j][7:0];
        end
      end
      2'b01: begin
        for (int j = 0; j < 4; j++) begin
          res_s[j*32 +: 16]    = exc_q[j] ? 16'hFFFF : low_nx_s[j][15:0];
          res_s[j*32+16 +: 16] = exc_q[j] ? 16'h0000 : rem_nx_s[j][15:0];
        end
      end
      2'b10: begin
        for (int j = 0; j < 2; j++) begin
          res_s[j*64 +: 32]    = exc_q[j] ? 32'hFFFF_FFFF : low_nx_s[j][31:0];
          res_s[j*64+32 +: 32] = exc_q[j] ? 32'h0000_0000 : rem_nx_s[j][31:0];
        end
      end
      default: begin
        res_s[63:0]   = exc_q[0] ? {64{1'b1}} : low_nx_s[0];
        res_s[127:64] = exc_q[0] ? 64'd0 : rem_nx_s[0];
      end
    endcase
  end

  // Next-state and datapath control; busy/done are computed for the next cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ww_d     = ww_q;
    rem_d    = rem_q;
    low_d    = low_q;
    dvs_d    = dvs_q;
    exc_d    = exc_q;
    result_d = result_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          cnt_d   = 7'd8 << bus.ctrl_ww;
          ww_d    = bus.ctrl_ww;
          rem_d   = ld_hi_s;
          low_d   = ld_lo_s;
          dvs_d   = ld_dv_s;
          exc_d   = ld_exc_s;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        rem_d = rem_nx_s;
        low_d = low_nx_s;
        cnt_d = cnt_q - 7'd1;
        if (cnt_q == 7'd1) begin
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = res_s;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 7'd0;
      ww_q     <= 2'b00;
      exc_q    <= 8'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 128'd0;
      for (int j = 0; j < 8; j++) begin
        rem_q[j] <= 64'd0;
        low_q[j] <= 64'd0;
        dvs_q[j] <= 64'd0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ww_q     <= ww_d;
      exc_q    <= exc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      low_q    <= low_d;
      dvs_q    <= dvs_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_unsdiv_seq.sv
// Self-checking bench for unsdiv_seq: directed cases, handshake corner cases
// and randomized operations compared against a plain-arithmetic lane model.
module tb_unsdiv_seq;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  unsdiv_seq_if bus ();

  unsdiv_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: per-lane unsigned divide with saturation on zero/overflow.
  function automatic logic [127:0] model(input logic [1:0] ww, input logic [127:0] a,
                                         input logic [127:0] b);
    int w, l, n;
    logic [127:0] res, m, dd, dv, q, r;
    w = 8 << ww;
    l = 2 * w;
    n = 128 / l;
    m = (128'd1 << w) - 128'd1;
    res = 128'd0;
    for (int k = 0; k < n; k++) begin
      dd = (a >> (k * l)) & ((m << w) | m);
      dv = (b >> (k * l)) & m;
      if (dv == 128'd0 || (dd >> w) >= dv) begin
        q = m;
        r = 128'd0;
      end else begin
        q = dd / dv;
        r = dd % dv;
      end
      res = res | ((((r & m) << w) | (q & m)) << (k * l));
    end
    return res;
  endfunction

  // Mostly reduce each lane's high half below its divisor so real quotients occur.
  function automatic logic [127:0] tame(input logic [1:0] ww, input logic [127:0] a,
                                        input logic [127:0] b);
    int w, l, n;
    logic [127:0] m, dv, hi, res;
    w = 8 << ww;
    l = 2 * w;
    n = 128 / l;
    m = (128'd1 << w) - 128'd1;
    res = a;
    for (int k = 0; k < n; k++) begin
      dv = (b >> (k * l)) & m;
      hi = (res >> (k * l + w)) & m;
      if (dv != 128'd0 && $urandom_range(0, 3) != 0) begin
        hi  = hi % dv;
        res = (res & ~(m << (k * l + w))) | (hi << (k * l + w));
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One operation: pulse start, optionally poke a start mid-run, check
  // latency, busy length, result and the single-cycle done pulse.
  task automatic run_op(input string tag, input logic [1:0] ww, input logic [127:0] a,
                        input logic [127:0] b, input logic [127:0] exp, input int poke);
    int cnt, busy_cnt, w;
    w = 8 << ww;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.ctrl_ww = ww;
    bus.reg_A   = a;
    bus.reg_B   = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.reg_A = rnd128();
    bus.reg_B = rnd128();
    cnt = 0;
    busy_cnt = 0;
    while (!bus.done && cnt < 100) begin
      if (bus.busy) busy_cnt++;
      if (cnt == poke) begin
        bus.start = 1'b1;
        bus.reg_A = ~a;
        bus.reg_B = ~b;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cnt++;
    end
    bus.start = 1'b0;
    chk({tag, "_latency"}, cnt, w);
    chk({tag, "_busy_len"}, busy_cnt, w);
    chk({tag, "_result"}, bus.result, exp);
    @(negedge clk);
    chk({tag, "_done_pulse"}, bus.done, 1'b0);
    chk({tag, "_idle"}, bus.busy, 1'b0);
  endtask

  initial begin
    logic [127:0] a1, b1, a2, b2;
    logic [1:0]   ww;
    int           cnt, gap, dones;
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    bus.start   = 1'b0;
    bus.ctrl_ww = 2'b00;
    bus.reg_A   = 128'd0;
    bus.reg_B   = 128'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_result", bus.result, 128'd0);
    reset = 1'b0;

    // Directed cases.
    run_op("w8_basic", 2'b00, {16'd200, 112'd0},
           {8'd0, 8'd7, {7{8'd0, 8'd1}}}, {8'd4, 8'd28, 112'd0}, -1);
    run_op("w16_basic", 2'b01, {32'd100000, 32'd0, 32'd0, 32'd65535},
           {16'd0, 16'd300, 16'd0, 16'd1, 16'd0, 16'd1, 16'd0, 16'd1},
           {16'd100, 16'd333, 32'd0, 32'd0, 16'd0, 16'hFFFF}, -1);
    run_op("w8_exc", 2'b00, {16'd200, 16'h1234, 16'h0A00, 16'd255, 64'd0},
           {8'd0, 8'd7, 8'd0, 8'd0, 8'd0, 8'd5, 8'd0, 8'd255, {4{8'd0, 8'd1}}},
           {8'd4, 8'd28, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'd0, 8'd1, 64'd0}, -1);
    run_op("w64_basic", 2'b11, 128'd1000, {64'd0, 64'd3}, {64'd1, 64'd333}, -1);
    run_op("w16_ignored", 2'b01, {32'd100000, 32'd0, 32'd0, 32'd65535},
           {16'd0, 16'd300, 16'd0, 16'd1, 16'd0, 16'd1, 16'd0, 16'd1},
           {16'd100, 16'd333, 32'd0, 32'd0, 16'd0, 16'hFFFF}, 3);

    // Back-to-back: start held through DONE launches the second operation.
    a1 = rnd128(); b1 = rnd128(); a1 = tame(2'b01, a1, b1);
    a2 = rnd128(); b2 = rnd128(); a2 = tame(2'b01, a2, b2);
    @(negedge clk);
    bus.start = 1'b1; bus.ctrl_ww = 2'b01; bus.reg_A = a1; bus.reg_B = b1;
    @(negedge clk);
    bus.reg_A = a2; bus.reg_B = b2;
    cnt = 0;
    while (!bus.done && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("b2b_first_latency", cnt, 16);
    chk("b2b_first_result", bus.result, model(2'b01, a1, b1));
    @(negedge clk);
    bus.start = 1'b0;
    gap = 1;
    while (!bus.done && gap < 100) begin
      @(negedge clk);
      gap++;
    end
    chk("b2b_gap", gap, 17);
    chk("b2b_second_result", bus.result, model(2'b01, a2, b2));
    @(negedge clk);

    // Reset in the middle of a w32 run.
    a1 = rnd128(); b1 = rnd128(); a1 = tame(2'b10, a1, b1);
    bus.start = 1'b1; bus.ctrl_ww = 2'b10; bus.reg_A = a1; bus.reg_B = b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_done", bus.done, 1'b0);
    chk("midrst_result", bus.result, 128'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("midrst_no_done", dones, 0);
    run_op("midrst_restart", 2'b10, a1, b1, model(2'b10, a1, b1), -1);

    // Randomized operations across all widths.
    for (int it = 0; it < 16; it++) begin
      ww = 2'(it % 4);
      a1 = rnd128();
      b1 = rnd128();
      if ($urandom_range(0, 3) == 0) b1 = b1 & {8{8'd0, 8'hFF}};
      a1 = tame(ww, a1, b1);
      run_op($sformatf("rand%0d", it), ww, a1, b1, model(ww, a1, b1), -1);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
